// File: rtl/pc_gen_pkg.sv
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared vectors, RAS depth default and next-PC select encoding
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_gen_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
    localparam int          DEF_RAS_DEPTH    = 4;

    typedef enum logic [2:0] {
        EXC    = 3'd0,
        HOLD   = 3'd1,
        JUMP   = 3'd2,
        JREG   = 3'd3,
        BRANCH = 3'd4,
        SEQ    = 3'd5
    } next_sel_e;

endpackage

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack with sticky over/underflow flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [XLEN-1:0]               i_data,
    output logic [XLEN-1:0]               o_top,
    output logic [$clog2(RAS_DEPTH):0]    o_count,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int              C_PW   = $clog2(RAS_DEPTH);
    localparam int              C_CW   = C_PW + 1;
    localparam logic [C_CW-1:0] C_FULL = C_CW'(RAS_DEPTH);

    logic [XLEN-1:0] r_stack [RAS_DEPTH];
    logic [C_PW-1:0] r_ptr;
    logic [C_CW-1:0] r_count;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_empty;
    logic            w_full;
    logic [C_PW-1:0] w_ptr_inc;
    logic [C_PW-1:0] w_ptr_dec;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL);
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_ptr_dec = r_ptr - 1'b1;

    // r_ptr indexes the top entry; the pointer wraps so a push when full lands on the oldest slot
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_pop && i_push) begin
            if (w_empty) begin
                r_underflow        <= 1'b1;
                r_ptr              <= w_ptr_inc;
                r_stack[w_ptr_inc] <= i_data;
                r_count            <= C_CW'(1);
            end else begin
                r_stack[r_ptr] <= i_data;
            end
        end else if (i_push) begin
            r_ptr              <= w_ptr_inc;
            r_stack[w_ptr_inc] <= i_data;
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_pop) begin
            if (w_empty) begin
                r_underflow <= 1'b1;
            end else begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_top       = w_empty ? '0 : r_stack[r_ptr];
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module      : pc_gen
// Description : Program counter generator with exception redirect and RAS
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
    parameter int              RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [31:0]                   Instr,
    input  logic [XLEN-1:0]               imm,
    input  logic                          Jump,
    input  logic                          Bzero,
    input  logic                          JumpReg,
    input  logic                          Link,
    input  logic                          Ret,
    input  logic                          Exc,
    input  logic [XLEN-1:0]               rs_val,
    output logic [XLEN-1:0]               PC,
    output logic [XLEN-1:0]               PC_plus4,
    output logic [XLEN-1:0]               epc,
    output logic [XLEN-1:0]               ras_top,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_miss,
    output logic                          ras_overflow,
    output logic                          ras_underflow
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_ras_miss;

    next_sel_e       w_sel;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;
    logic            w_active;
    logic            w_push;
    logic            w_pop;
    logic            w_ras_empty;
    logic            w_unused;

    assign w_unused   = ^Instr[31:26];
    assign w_pc_plus4 = r_pc + XLEN'(4);

    always_comb begin
        w_sel = SEQ;
        if (Exc) begin
            w_sel = EXC;
        end else if (stall) begin
            w_sel = HOLD;
        end else if (Jump) begin
            w_sel = JUMP;
        end else if (JumpReg) begin
            w_sel = JREG;
        end else if (Bzero) begin
            w_sel = BRANCH;
        end
    end

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (w_sel)
            EXC:     w_pc_next = EXC_VECTOR;
            HOLD:    w_pc_next = r_pc;
            JUMP:    w_pc_next = {w_pc_plus4[XLEN-1:28], Instr[25:0], 2'b00};
            JREG:    w_pc_next = rs_val;
            BRANCH:  w_pc_next = w_pc_plus4 + (imm << 2);
            default: w_pc_next = w_pc_plus4;
        endcase
    end

    // RAS traffic only happens on cycles that actually advance the PC
    assign w_active    = !Exc && !stall;
    assign w_push      = w_active && Link && (Jump || JumpReg);
    assign w_pop       = w_active && Ret && JumpReg;
    assign w_ras_empty = (ras_count == '0);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_VECTOR;
            r_epc      <= '0;
            r_ras_miss <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_ras_miss <= w_pop && (w_ras_empty || (ras_top != rs_val));
            if (w_sel == EXC) begin
                r_epc <= r_pc;
            end
        end
    end

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK         (CLK),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_data      (w_pc_plus4),
        .o_top       (ras_top),
        .o_count     (ras_count),
        .o_overflow  (ras_overflow),
        .o_underflow (ras_underflow)
    );

    assign PC       = r_pc;
    assign PC_plus4 = w_pc_plus4;
    assign epc      = r_epc;
    assign ras_miss = r_ras_miss;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen against a queue-based model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] EV    = 32'h0000_0080;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] Instr = '0;
    logic [31:0] imm = '0;
    logic        Jump = 1'b0, Bzero = 1'b0, JumpReg = 1'b0;
    logic        Link = 1'b0, Ret = 1'b0, Exc = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] PC, PC_plus4, epc, ras_top;
    logic [2:0]  ras_count;
    logic        ras_miss, ras_overflow, ras_underflow;

    int total = 0;
    int bad   = 0;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .stall         (stall),
        .Instr         (Instr),
        .imm           (imm),
        .Jump          (Jump),
        .Bzero         (Bzero),
        .JumpReg       (JumpReg),
        .Link          (Link),
        .Ret           (Ret),
        .Exc           (Exc),
        .rs_val        (rs_val),
        .PC            (PC),
        .PC_plus4      (PC_plus4),
        .epc           (epc),
        .ras_top       (ras_top),
        .ras_count     (ras_count),
        .ras_miss      (ras_miss),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stack is a queue with element 0 as top, capped at DEPTH
    logic [31:0] m_pc = RV, m_epc = '0;
    logic        m_miss = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    logic [31:0] m_ras [$];

    always @(posedge CLK or negedge reset) begin
        logic [31:0] p4;
        if (!reset) begin
            m_pc = RV; m_epc = '0; m_miss = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            m_ras.delete();
        end else begin
            p4 = m_pc + 32'd4;
            m_miss = 1'b0;
            if (Exc) begin
                m_epc = m_pc;
                m_pc  = EV;
            end else if (!stall) begin
                if (Ret && JumpReg) begin
                    if (m_ras.size() == 0) begin
                        m_miss = 1'b1;
                        m_udf  = 1'b1;
                    end else begin
                        m_miss = (m_ras[0] != rs_val);
                        void'(m_ras.pop_front());
                    end
                end
                if (Link && (Jump || JumpReg)) begin
                    m_ras.push_front(p4);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_back());
                        m_ovf = 1'b1;
                    end
                end
                if (Jump)         m_pc = {p4[31:28], Instr[25:0], 2'b00};
                else if (JumpReg) m_pc = rs_val;
                else if (Bzero)   m_pc = p4 + (imm << 2);
                else              m_pc = p4;
            end
        end
    end

    always @(negedge CLK) begin
        check("pc", PC, m_pc);
        check("pc_plus4", PC_plus4, m_pc + 32'd4);
        check("epc", epc, m_epc);
        check("ras_top", ras_top, (m_ras.size() > 0) ? m_ras[0] : 32'd0);
        check("ras_count", {29'd0, ras_count}, 32'(m_ras.size()));
        check("ras_miss", {31'd0, ras_miss}, {31'd0, m_miss});
        check("ras_overflow", {31'd0, ras_overflow}, {31'd0, m_ovf});
        check("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_udf});
    end

    task automatic clr();
        {Jump, Bzero, JumpReg, Link, Ret, Exc, stall} = '0;
        Instr = '0; imm = '0; rs_val = '0;
    endtask

    // Apply one set of controls across a rising edge; returns #1 after it
    task automatic cyc(input logic j, input logic jr, input logic bz, input logic lk,
                       input logic rt, input logic ex, input logic st,
                       input logic [31:0] ins, input logic [31:0] im, input logic [31:0] rs);
        Jump = j; JumpReg = jr; Bzero = bz; Link = lk; Ret = rt; Exc = ex; stall = st;
        Instr = ins; imm = im; rs_val = rs;
        @(posedge CLK); #1;
        clr();
    endtask

    initial begin
        #3 reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", PC, RV);
        check("rst_count", {29'd0, ras_count}, 32'd0);
        check("rst_flags", {29'd0, ras_miss, ras_overflow, ras_underflow}, 32'd0);
        reset = 1'b1;

        // sequential fetch
        for (int i = 1; i <= 3; i++) begin
            cyc(0,0,0,0,0,0,0, '0, '0, '0);
            check("seq_pc", PC, 32'(4 * i));
        end

        // jump then backward branch
        cyc(0,1,0,0,0,0,0, '0, '0, 32'h1000_0010);
        cyc(1,0,0,0,0,0,0, 32'h0000_0040, '0, '0);
        check("jump_pc", PC, 32'h1000_0100);
        cyc(0,0,1,0,0,0,0, '0, 32'hFFFF_FFFC, '0);
        check("branch_pc", PC, 32'h1000_00F4);

        // call / return
        cyc(0,1,0,0,0,0,0, '0, '0, 32'h0000_0100);
        cyc(1,0,0,1,0,0,0, 32'h0000_0080, '0, '0);
        check("call_top", ras_top, 32'h104);
        check("call_count", {29'd0, ras_count}, 32'd1);
        cyc(0,1,0,0,1,0,0, '0, '0, 32'h0000_0104);
        check("ret_pc", PC, 32'h104);
        check("ret_count", {29'd0, ras_count}, 32'd0);
        check("ret_miss", {31'd0, ras_miss}, 32'd0);
        cyc(0,1,0,0,1,0,0, '0, '0, 32'h0000_0200);
        check("empty_miss", {31'd0, ras_miss}, 32'd1);
        check("underflow", {31'd0, ras_underflow}, 32'd1);
        cyc(0,0,0,0,0,0,0, '0, '0, '0);
        check("miss_pulse", {31'd0, ras_miss}, 32'd0);

        // five pushes into a four-deep stack, PC starts at 0x204
        cyc(0,1,0,1,0,0,0, '0, '0, 32'h1000);
        for (int i = 1; i <= 4; i++) cyc(0,1,0,1,0,0,0, '0, '0, 32'h1000 + 32'(i * 32'h100));
        check("ovf_count", {29'd0, ras_count}, 32'd4);
        check("ovf_flag", {31'd0, ras_overflow}, 32'd1);
        for (int i = 3; i >= 0; i--) begin
            check("lifo_top", ras_top, 32'h1004 + 32'(i * 32'h100));
            cyc(0,1,0,0,1,0,0, '0, '0, 32'h1004 + 32'(i * 32'h100));
            check("lifo_miss", {31'd0, ras_miss}, 32'd0);
        end
        check("lifo_empty", {29'd0, ras_count}, 32'd0);

        // stall and exception
        cyc(1,0,0,0,0,0,1, 32'h0000_0123, '0, '0);
        check("stall_pc", PC, 32'h1004);
        cyc(0,1,0,0,0,0,0, '0, '0, 32'h40);
        cyc(0,0,0,0,0,1,1, '0, '0, '0);
        check("exc_pc", PC, 32'h80);
        check("exc_epc", epc, 32'h40);

        // reset in the middle of a call
        Jump = 1'b1; Link = 1'b1; Instr = 32'h0000_0400;
        #2 reset = 1'b0;
        #1;
        check("midrst_pc", PC, RV);
        check("midrst_count", {29'd0, ras_count}, 32'd0);
        check("midrst_epc", epc, 32'd0);
        @(posedge CLK); #1;
        clr();
        reset = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_pc", PC, RV + 32'd4);
        check("post_rst_count", {29'd0, ras_count}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            r = $urandom;
            Jump    = ($urandom_range(0, 9) == 0);
            JumpReg = ($urandom_range(0, 4) == 0);
            Bzero   = ($urandom_range(0, 5) == 0);
            Link    = ($urandom_range(0, 2) == 0);
            Ret     = ($urandom_range(0, 2) == 0);
            Exc     = ($urandom_range(0, 39) == 0);
            stall   = ($urandom_range(0, 9) == 0);
            Instr   = $urandom;
            imm     = 32'($urandom_range(0, 64)) - 32'd32;
            if (m_ras.size() > 0 && r[0]) rs_val = m_ras[0];
            else if (r[1]) rs_val = $urandom;
            else rs_val = {$urandom_range(0, 16'hFFFF), 2'b00};
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                @(posedge CLK); #1;
                reset = 1'b1;
            end else begin
                @(posedge CLK); #1;
            end
        end
        clr();
        @(negedge CLK); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
Parameters (name, default, meaning):
REQ-001 XLEN, 32, PC/address width; SHALL be >= 32.
REQ-002 RESET_VECTOR, 32'h0000_0000, PC value after reset.
REQ-003 EXC_VECTOR, 32'h0000_0080, PC value on exception redirect.
REQ-004 RAS_DEPTH, 4, return-address-stack entries; SHALL be a power of 2 and >= 2.
Ports (name, direction, width, meaning):
REQ-005 CLK  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold PC and all state this cycle.
REQ-008 Instr  in  32  current instruction; bits [25:0] are the J-type target field.
REQ-009 imm  in  XLEN  sign-extended branch offset, in words.
REQ-010 Jump, Bzero, JumpReg, Link, Ret, Exc  in  1 each  J-type jump, branch taken, register jump, link (push return address), return (pop RAS), exception request.
REQ-011 rs_val  in  XLEN  register-jump target.
REQ-012 PC  out  XLEN  current PC, registered.
REQ-013 PC_plus4  out  XLEN  PC+4, combinational from PC.
REQ-014 epc  out  XLEN  PC captured at the last exception.
REQ-015 ras_top  out  XLEN  top RAS entry; 0 when the stack is empty.
REQ-016 ras_count  out  $clog2(RAS_DEPTH)+1  number of valid entries.
REQ-017 ras_miss  out  1  one-cycle registered pulse: return prediction wrong.
REQ-018 ras_overflow, ras_underflow  out  1 each  sticky error flags.

Function
REQ-019 Next-PC priority SHALL be Exc > stall > Jump > JumpReg > Bzero > sequential.
REQ-020 Exc: PC <= EXC_VECTOR and epc <= PC; RAS unchanged; stall ignored.
REQ-021 stall (no Exc): PC, epc, RAS, count and flags hold; ras_miss <= 0.
REQ-022 Jump: PC <= {PC_plus4[XLEN-1:28], Instr[25:0], 2'b00}.
REQ-023 JumpReg: PC <= rs_val, used as-is with no alignment masking.
REQ-024 Bzero: PC <= PC_plus4 + (imm << 2), modulo 2^XLEN.
REQ-025 Otherwise PC <= PC_plus4; PC wraps from 2^XLEN-4 to 0.
REQ-026 Link with Jump or JumpReg (not stalled, no Exc): push PC_plus4 onto the RAS.
REQ-027 Ret with JumpReg (not stalled, no Exc): pop the RAS; ras_miss <= 1 if the stack was empty or the old top != rs_val, else 0.
REQ-028 Link and Ret both set with JumpReg: pop, then push; top becomes PC_plus4 and count is unchanged.
REQ-029 Push when full: overwrite the oldest entry (circular); count stays RAS_DEPTH; ras_overflow <= 1.
REQ-030 Pop when empty: count stays 0; ras_underflow <= 1.
REQ-031 Link or Ret without the matching jump type: ignored.
REQ-032 ras_miss SHALL be 0 in every cycle not covered by REQ-027.

Reset
REQ-033 On reset low, asynchronously: PC = RESET_VECTOR; epc, ras_top, ras_count = 0; ras_miss, ras_overflow, ras_underflow = 0; RAS entries = 0.
REQ-034 Reset asserted mid-operation SHALL discard any pending redirect or push; the first edge after release performs a normal update from RESET_VECTOR.
REQ-035 Sticky flags SHALL clear only by reset.

Structure
REQ-036 A shared package SHALL hold the default vectors, the next-PC select enum (EXC, HOLD, JUMP, JREG, BRANCH, SEQ) and the RAS_DEPTH default.
REQ-037 The RAS SHALL be a sub-module, pc_ras, with push, pop, top, count and flags; pc_gen holds next-PC selection and the PC/epc registers.

Verification
REQ-038 Release reset, no controls for 3 cycles -> PC = 0, 4, 8, 12.
REQ-039 PC = 0x1000_0010, Jump, Instr[25:0] = 0x000_0040 -> PC = 0x1000_0100; then Bzero, imm = -4 -> PC = 0x1000_00F4.
REQ-040 PC = 0x100: Jump+Link -> ras_top = 0x104, count = 1; then JumpReg+Ret, rs_val = 0x104 -> PC = 0x104, count = 0, ras_miss = 0; a repeat with rs_val = 0x200 -> ras_miss = 1 and ras_underflow = 1.
REQ-041 Five pushes with RAS_DEPTH = 4 -> count = 4, ras_overflow = 1, and four pops return the last four addresses in LIFO order.
REQ-042 stall together with Jump -> PC unchanged; stall together with Exc at PC = 0x40 -> PC = 0x80, epc = 0x40.
REQ-043 Assert reset between clock edges during a Jump+Link -> PC = RESET_VECTOR and count = 0 immediately, with no push.
